serial_adder: RTL and testbench

- Bit-serial unsigned adder built around the team's half_adder cell.
- Two half_adder instances plus an OR form a full adder; a carry flip-flop closes the loop across cycles.
- Operands are latched on a start pulse and processed LSB-first, one bit per clock; the WIDTH-bit sum and carry-out are presented with a one-cycle done strobe.
- Sits directly downstream of half_adder, consuming its s/c outputs as the per-bit datapath of a sequential multi-bit adder.

---
 rtl/serial_adder.sv | 70 +++++++
 tb/tb_serial_adder.sv | 104 ++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial unsigned adder built from two half_adder cells and a carry flop.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0] cnt;
  logic carry, s0, c0, bit_s, c1, carry_next;
  half_adder ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(s0), .c(c0));
  half_adder ha1 (.x(s0), .y(carry), .s(bit_s), .c(c1));
  assign carry_next = c0 | c1;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= RUN;
        a_sr  <= a;
        b_sr  <= b;
        sum   <= '0;
        cout  <= 1'b0;
        carry <= 1'b0;
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      // Result enters at the MSB so after WIDTH shifts bit 0 sits at sum[0].
      sum   <= WIDTH'({bit_s, sum} >> 1);
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= carry_next;
      cnt   <= CW'(cnt + 1'b1);
      if (cnt == CW'(WIDTH - 1)) begin
        state <= DONE;
        cout  <= carry_next;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed checks of serial_adder against plain a+b arithmetic.
module tb_serial_adder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic busy, done, cout;
  int nvec = 0, nerr = 0, dones = 0, starts = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) dones++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_res"}, 32'({cout, sum}), 0);
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] exp;
    int n;
    exp = {1'b0, x} + {1'b0, y};
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; starts++;
    a = 8'($urandom); b = 8'($urandom);
    n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk);
    end while (done !== 1'b1 && n < 20);
    chk("latency", 32'(n), 8);
    chk("busy_at_done", 32'(busy), 1);
    chk("result", 32'({cout, sum}), 32'(exp));
    @(posedge clk); @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("busy_after", 32'(busy), 0);
    chk("hold", 32'({cout, sum}), 32'(exp));
  endtask

  initial begin
    start = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_idle_zero("reset");
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_idle_zero("post_reset");
    end

    op(8'h05, 8'h03);
    op(8'hFF, 8'h01);
    op(8'hFF, 8'hFF);
    op(8'h00, 8'h00);

    // A second request during RUN and a held start during DONE are both dropped.
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; starts++;
    repeat (3) @(posedge clk);
    #1 a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk("busy_done", 32'(done), 1);
    chk("busy_res", 32'({cout, sum}), 32'h30);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_idle", 32'(busy), 0);
    chk("busy_hold", 32'({cout, sum}), 32'h30);
    repeat (12) @(negedge clk);
    chk("busy_dones", 32'(dones), 32'(starts));

    // Reset mid-operation discards everything.
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("mid_reset");
    repeat (10) @(negedge clk);
    chk("mid_reset_dones", 32'(dones), 32'(starts));
    op(8'h01, 8'h01);

    for (int i = 0; i < 200; i++) op(8'($urandom), 8'($urandom));
    repeat (3) @(negedge clk);
    chk("done_count", 32'(dones), 32'(starts));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
